// File: rtl/alu_ex_stage.sv
// EX pipeline stage: forwarding muxes, ALU, and the EX/MEM pipeline register.
// The register honours reset > flush > stall > load, and a bubble clears every output.
module alu_ex_stage #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [3:0]        alu_action,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic [DATA_W-1:0] imm,
    input  logic              alu_src,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [4:0]        rd_in,
    input  logic              reg_write_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              mem_to_reg_in,
    input  logic              branch_in,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] alu_result,
    output logic              zero,
    output logic              overflow,
    output logic [DATA_W-1:0] store_data,
    output logic [4:0]        rd_out,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              branch_taken
);

    localparam int MSB = DATA_W - 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic              valid_reg;
    logic [DATA_W-1:0] result_reg;
    logic              zero_reg;
    logic              ovf_reg;
    logic [DATA_W-1:0] store_reg;
    logic [4:0]        rd_reg;
    logic              reg_write_reg;
    logic              mem_read_reg;
    logic              mem_write_reg;
    logic              mem_to_reg_reg;
    logic              taken_reg;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b_fwd;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] bit_and;
    logic [DATA_W-1:0] bit_or;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              slt_bit;
    logic              add_ovf;
    logic              sub_ovf;
    logic [DATA_W-1:0] result_next;
    logic              ovf_next;
    logic              zero_next;
    logic              bubble;

    // EX/MEM forwarding taps the registered result, so a held (stalled) result keeps forwarding.
    always_comb begin
        case (fwd_a)
            2'b10:   op_a = result_reg;
            2'b01:   op_a = wb_data;
            default: op_a = rs_data;
        endcase
        case (fwd_b)
            2'b10:   op_b_fwd = result_reg;
            2'b01:   op_b_fwd = wb_data;
            default: op_b_fwd = rt_data;
        endcase
    end

    assign op_b = alu_src ? imm : op_b_fwd;

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bitwise
        assign bit_and[gi] = op_a[gi] & op_b[gi];
        assign bit_or[gi]  = op_a[gi] | op_b[gi];
    end

    assign sum     = op_a + op_b;
    assign diff    = op_a - op_b;
    assign slt_bit = $signed(op_a) < $signed(op_b);
    // Signed overflow: result sign disagrees with what the operand signs allow.
    assign add_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
    assign sub_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);

    always_comb begin
        result_next = '0;
        ovf_next    = 1'b0;
        case (alu_action)
            OP_AND: result_next = bit_and;
            OP_OR:  result_next = bit_or;
            OP_ADD: begin
                result_next = sum;
                ovf_next    = add_ovf;
            end
            OP_SUB: begin
                result_next = diff;
                ovf_next    = sub_ovf;
            end
            OP_SLT: result_next = {{(DATA_W-1){1'b0}}, slt_bit};
            OP_NOR: result_next = ~bit_or;
            default: begin
                result_next = '0;
                ovf_next    = 1'b0;
            end
        endcase
    end

    assign zero_next = (result_next == '0);
    assign bubble    = flush || (!stall && !in_valid);

    always_ff @(posedge clk) begin
        if (!rst_n || bubble) begin
            valid_reg      <= 1'b0;
            result_reg     <= '0;
            zero_reg       <= 1'b0;
            ovf_reg        <= 1'b0;
            store_reg      <= '0;
            rd_reg         <= '0;
            reg_write_reg  <= 1'b0;
            mem_read_reg   <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            taken_reg      <= 1'b0;
        end else if (!stall) begin
            valid_reg      <= 1'b1;
            result_reg     <= result_next;
            zero_reg       <= zero_next;
            ovf_reg        <= ovf_next;
            store_reg      <= op_b_fwd;
            rd_reg         <= rd_in;
            reg_write_reg  <= reg_write_in;
            mem_read_reg   <= mem_read_in;
            mem_write_reg  <= mem_write_in;
            mem_to_reg_reg <= mem_to_reg_in;
            taken_reg      <= branch_in && zero_next;
        end
    end

    assign out_valid    = valid_reg;
    assign alu_result   = result_reg;
    assign zero         = zero_reg;
    assign overflow     = ovf_reg;
    assign store_data   = store_reg;
    assign rd_out       = rd_reg;
    assign reg_write    = reg_write_reg;
    assign mem_read     = mem_read_reg;
    assign mem_write    = mem_write_reg;
    assign mem_to_reg   = mem_to_reg_reg;
    assign branch_taken = taken_reg;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: the driver predicts each edge's outputs with a
// signed-integer reference model; a monitor pops and compares one prediction per edge.
module tb_alu_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  alu_action;
    logic [31:0] rs_data, rt_data, imm, wb_data;
    logic        alu_src;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, branch_in;
    logic        stall, flush;

    logic        out_valid, zero, overflow;
    logic [31:0] alu_result, store_data;
    logic [4:0]  rd_out;
    logic        reg_write, mem_read, mem_write, mem_to_reg, branch_taken;

    typedef struct {
        logic        valid;
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        rw, mr, mw, m2r, bt;
    } out_t;

    out_t exp_q[$];
    out_t model;
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    always #5 clk = ~clk;

    alu_ex_stage #(.DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_action(alu_action),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .alu_src(alu_src),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_data(wb_data), .rd_in(rd_in),
        .reg_write_in(reg_write_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
        .branch_in(branch_in), .stall(stall), .flush(flush),
        .out_valid(out_valid), .alu_result(alu_result), .zero(zero),
        .overflow(overflow), .store_data(store_data), .rd_out(rd_out),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_to_reg(mem_to_reg), .branch_taken(branch_taken)
    );

    function automatic out_t empty_out();
        out_t o;
        o.valid = 0; o.result = 0; o.zero = 0; o.ovf = 0; o.store = 0;
        o.rd = 0; o.rw = 0; o.mr = 0; o.mw = 0; o.m2r = 0; o.bt = 0;
        return o;
    endfunction

    // Reference ALU on true signed integers; overflow means the exact answer does not fit 32 bits.
    function automatic void alu_ref(input logic [3:0] act, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic ovf);
        longint sa, sb, full;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        ovf = 0;
        case (act)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b);
            4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
            4'b0010, 4'b0110: begin
                full = (act == 4'b0010) ? sa + sb : sa - sb;
                r = full[31:0];
                ovf = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            default: begin r = 0; ovf = 0; end
        endcase
    endfunction

    function automatic logic [31:0] pick_src(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'b10) return model.result;
        if (sel == 2'b01) return wb_data;
        return rf;
    endfunction

    // Predict outputs after the coming edge, queue them, and advance past that edge.
    task automatic cycle();
        out_t nx;
        logic [31:0] a, bpre, r;
        logic ovf;
        if (!rst_n || flush) nx = empty_out();
        else if (stall) nx = model;
        else if (!in_valid) nx = empty_out();
        else begin
            a    = pick_src(fwd_a, rs_data);
            bpre = pick_src(fwd_b, rt_data);
            alu_ref(alu_action, a, alu_src ? imm : bpre, r, ovf);
            nx.valid = 1; nx.result = r; nx.ovf = ovf; nx.zero = (r == 0);
            nx.store = bpre; nx.rd = rd_in; nx.rw = reg_write_in; nx.mr = mem_read_in;
            nx.mw = mem_write_in; nx.m2r = mem_to_reg_in; nx.bt = branch_in && (r == 0);
        end
        model = nx;
        exp_q.push_back(nx);
        @(negedge clk);
        #1;
    endtask

    task automatic set_nop();
        rst_n = 1; in_valid = 0; alu_action = 0; rs_data = 0; rt_data = 0; imm = 0;
        alu_src = 0; fwd_a = 0; fwd_b = 0; wb_data = 0; rd_in = 0; reg_write_in = 0;
        mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; branch_in = 0;
        stall = 0; flush = 0;
    endtask

    task automatic set_op(input logic [3:0] act, input logic [31:0] a, input logic [31:0] b);
        set_nop();
        in_valid = 1; alu_action = act; rs_data = a; rt_data = b;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pick_val();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 8));
            1: return edges[$urandom_range(0, 4)];
            default: return $urandom;
        endcase
    endfunction

    task automatic randomize_inputs();
        logic [3:0] ops [8];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
        rst_n = ($urandom_range(0, 29) != 0);
        stall = ($urandom_range(0, 4) == 0);
        flush = ($urandom_range(0, 9) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        alu_action = ($urandom_range(0, 4) == 0) ? 4'($urandom) : ops[$urandom_range(0, 7)];
        rs_data = pick_val();
        rt_data = ($urandom_range(0, 5) == 0) ? rs_data : pick_val();
        imm = pick_val();
        wb_data = pick_val();
        alu_src = 1'($urandom);
        fwd_a = 2'($urandom);
        fwd_b = 2'($urandom);
        rd_in = 5'($urandom);
        reg_write_in = 1'($urandom); mem_read_in = 1'($urandom);
        mem_write_in = 1'($urandom); mem_to_reg_in = 1'($urandom);
        branch_in = 1'($urandom);
    endtask

    // Monitor: the EX/MEM register presents a fresh slot every edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                checks++;
                if (out_valid !== e.valid || alu_result !== e.result || zero !== e.zero ||
                    overflow !== e.ovf || store_data !== e.store || rd_out !== e.rd ||
                    reg_write !== e.rw || mem_read !== e.mr || mem_write !== e.mw ||
                    mem_to_reg !== e.m2r || branch_taken !== e.bt) begin
                    errors++;
                    $display("FAIL txn %0d: got v=%b r=%h z=%b o=%b s=%h rd=%0d c=%b%b%b%b bt=%b expected v=%b r=%h z=%b o=%b s=%h rd=%0d c=%b%b%b%b bt=%b",
                             txn, out_valid, alu_result, zero, overflow, store_data, rd_out,
                             reg_write, mem_read, mem_write, mem_to_reg, branch_taken,
                             e.valid, e.result, e.zero, e.ovf, e.store, e.rd,
                             e.rw, e.mr, e.mw, e.m2r, e.bt);
                end else begin
                    $display("txn %0d ok: v=%b r=%h z=%b o=%b s=%h rd=%0d bt=%b",
                             txn, out_valid, alu_result, zero, overflow, store_data,
                             rd_out, branch_taken);
                end
            end
        end
    end

    initial begin
        model = empty_out();
        set_nop();
        // Reset wins over stall and a valid instruction.
        rst_n = 0; in_valid = 1; stall = 1; alu_action = 4'b0010; rs_data = 9;
        cycle();
        cycle();
        chk("reset_valid", out_valid, 0);
        chk("reset_result", alu_result, 0);

        set_op(4'b0010, 32'h7FFF_FFFF, 32'h1);
        cycle();
        chk("add_ovf_result", alu_result, 32'h8000_0000);
        chk("add_ovf_flag", overflow, 1);
        chk("add_ovf_zero", zero, 0);
        chk("add_ovf_valid", out_valid, 1);

        set_op(4'b0110, 5, 5); branch_in = 1;
        cycle();
        chk("sub_zero", zero, 1);
        chk("sub_taken", branch_taken, 1);
        in_valid = 0;
        cycle();
        chk("bubble_taken", branch_taken, 0);
        chk("bubble_valid", out_valid, 0);

        set_op(4'b0111, 32'hFFFF_FFFF, 32'h1);
        cycle();
        chk("slt_neg", alu_result, 1);
        set_op(4'b0111, 32'h1, 32'hFFFF_FFFF);
        cycle();
        chk("slt_pos", alu_result, 0);
        set_op(4'b0011, 32'h1234, 32'h5678);
        cycle();
        chk("undef_result", alu_result, 0);
        chk("undef_zero", zero, 1);

        set_op(4'b0010, 2, 3);
        cycle();
        set_op(4'b0010, 32'hDEAD, 4); fwd_a = 2'b10;
        cycle();
        chk("fwd_exmem", alu_result, 9);
        set_op(4'b0010, 1, 32'h77); fwd_b = 2'b01; wb_data = 10;
        cycle();
        chk("fwd_store", store_data, 10);

        set_op(4'b0001, 32'h1234, 0); rd_in = 3; reg_write_in = 1;
        cycle();
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            rst_n = 1; stall = 1; flush = 0;
            cycle();
            chk("stall_hold", alu_result, 32'h1234);
        end
        stall = 1; flush = 1; in_valid = 1; reg_write_in = 1;
        cycle();
        chk("flush_valid", out_valid, 0);
        chk("flush_rw", reg_write, 0);

        set_op(4'b0010, 40, 2); reg_write_in = 1; rd_in = 7;
        cycle();
        stall = 1; rst_n = 0;
        cycle();
        chk("rst_stall_valid", out_valid, 0);
        chk("rst_stall_result", alu_result, 0);
        chk("rst_stall_rd", 32'(rd_out), 0);
        set_op(4'b0001, 32'hF0, 32'h0F);
        cycle();
        chk("post_reset_or", alu_result, 32'hFF);

        for (int i = 0; i < 300; i++) begin
            randomize_inputs();
            cycle();
        end

        set_nop();
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
